// File: rtl/guess_hint_sequencer.sv
// guess_hint_sequencer: scores one guess (green, then yellow pass) and uploads the guess row plus hints to board RAM.
// The RAM upload stages are built only when GUESS_HINT_RAM_UPLOAD_EN is defined.
module guess_hint_sequencer #(
  parameter int MAX_PINS     = 20,
  parameter int COLOR_W      = 8,
  parameter int MAX_GUESSES  = 99,
  parameter int ADDR_W       = 12,
  parameter int HINTS_OFFSET = MAX_PINS * MAX_GUESSES
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        start,
  input  logic [7:0]                  pins_count,
  input  logic [7:0]                  guess_index,
  input  logic [MAX_PINS*COLOR_W-1:0] guess,
  input  logic [MAX_PINS*COLOR_W-1:0] secret,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [7:0]                  green,
  output logic [7:0]                  yellow,
  output logic                        ram_req,
  input  logic                        ram_gnt,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [7:0]                  ram_wdata
);
  localparam int PW = MAX_PINS * COLOR_W;
  localparam int IW = $clog2(MAX_PINS + 1);
  typedef enum logic [2:0] {IDLE, GREEN, YELLOW, UP_GUESS, UP_HINTS, DONE} state_t;
  state_t st;
  logic [PW-1:0] g_q, s_q;
  logic [7:0] idx_q;
  logic [IW-1:0] n_q, i_q, j_q;
  logic [MAX_PINS-1:0] ag_m, as_m;
  logic bad;
  assign bad = 32'(idx_q) >= MAX_GUESSES;
  function automatic logic [COLOR_W-1:0] pin(input logic [PW-1:0] v, input logic [IW-1:0] k);
    return v[32'(k)*COLOR_W +: COLOR_W];
  endfunction
`ifdef GUESS_HINT_RAM_UPLOAD_EN
  function automatic logic [ADDR_W-1:0] row_addr(input logic [IW-1:0] k);
    return ADDR_W'(idx_q) * ADDR_W'(MAX_PINS) + ADDR_W'(k);
  endfunction
  function automatic logic [ADDR_W-1:0] hint_addr();
    return ADDR_W'(HINTS_OFFSET) + ADDR_W'({idx_q, 1'b0});
  endfunction
`else
  logic unused_gnt;
  assign unused_gnt = ram_gnt;
  assign ram_req   = 1'b0;
  assign ram_addr  = '0;
  assign ram_wdata = '0;
`endif
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      st     <= IDLE;
      g_q    <= '0;
      s_q    <= '0;
      idx_q  <= '0;
      n_q    <= '0;
      i_q    <= '0;
      j_q    <= '0;
      ag_m   <= '0;
      as_m   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      green  <= '0;
      yellow <= '0;
`ifdef GUESS_HINT_RAM_UPLOAD_EN
      ram_req   <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
`endif
    end else begin
      case (st)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            g_q    <= guess;
            s_q    <= secret;
            idx_q  <= guess_index;
            n_q    <= 32'(pins_count) > MAX_PINS ? IW'(MAX_PINS) : pins_count[IW-1:0];
            i_q    <= '0;
            j_q    <= '0;
            ag_m   <= '0;
            as_m   <= '0;
            green  <= '0;
            yellow <= '0;
            err    <= 1'b0;
            busy   <= 1'b1;
            st     <= GREEN;
          end
        end
        GREEN: begin
          if (i_q == n_q) begin
            i_q <= '0;
            j_q <= '0;
            st  <= YELLOW;
          end else begin
            if (pin(g_q, i_q) == pin(s_q, i_q)) begin
              green      <= green + 8'd1;
              ag_m[i_q]  <= 1'b1;
              as_m[i_q]  <= 1'b1;
            end
            i_q <= i_q + 1'b1;
          end
        end
        YELLOW: begin
          if (i_q == n_q) begin
`ifdef GUESS_HINT_RAM_UPLOAD_EN
            if (bad) st <= DONE;
            else if (n_q == '0) begin
              ram_req   <= 1'b1;
              ram_addr  <= hint_addr();
              ram_wdata <= green;
              j_q       <= '0;
              st        <= UP_HINTS;
            end else begin
              ram_req   <= 1'b1;
              ram_addr  <= row_addr('0);
              ram_wdata <= 8'(pin(g_q, '0));
              i_q       <= '0;
              st        <= UP_GUESS;
            end
`else
            st <= DONE;
`endif
          end else if (ag_m[i_q] || j_q == n_q) begin
            i_q <= i_q + 1'b1;
            j_q <= '0;
          end else if (!as_m[j_q] && pin(g_q, i_q) == pin(s_q, j_q)) begin
            yellow     <= yellow + 8'd1;
            as_m[j_q]  <= 1'b1;
            i_q        <= i_q + 1'b1;
            j_q        <= '0;
          end else j_q <= j_q + 1'b1;
        end
`ifdef GUESS_HINT_RAM_UPLOAD_EN
        // each accepted write immediately presents the next one
        UP_GUESS: if (ram_gnt) begin
          if (i_q + 1'b1 == n_q) begin
            ram_addr  <= hint_addr();
            ram_wdata <= green;
            j_q       <= '0;
            st        <= UP_HINTS;
          end else begin
            ram_addr  <= row_addr(i_q + 1'b1);
            ram_wdata <= 8'(pin(g_q, i_q + 1'b1));
            i_q       <= i_q + 1'b1;
          end
        end
        UP_HINTS: if (ram_gnt) begin
          if (!j_q[0]) begin
            ram_addr  <= ram_addr + 1'b1;
            ram_wdata <= yellow;
            j_q       <= 1;
          end else begin
            ram_req <= 1'b0;
            st      <= DONE;
          end
        end
`endif
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          err  <= bad;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_guess_hint_sequencer.sv
// tb_guess_hint_sequencer: random and directed scoring runs checked against a colour-count reference model.
module tb_guess_hint_sequencer;
  localparam int P = 20, G = 99, HO = 1980;
  logic clk = 0, nrst = 0, start = 0, ram_gnt = 0;
  logic [7:0] pins_count = 0, guess_index = 0;
  logic [P*8-1:0] guess = '0, secret = '0;
  logic busy, done, err, ram_req;
  logic [7:0] green, yellow, ram_wdata;
  logic [11:0] ram_addr;
  int tests = 0, fails = 0, lat_mode = 0, done_cnt = 0, req_seen = 0, hold = 0;
  int wq[$];
  logic [7:0] tg[P], ts[P];
  logic p_req = 0, p_gnt = 0;
  logic [11:0] p_addr = 0;
  logic [7:0] p_data = 0;

  always #5 clk = ~clk;

  guess_hint_sequencer dut (
    .clk(clk), .nrst(nrst), .start(start), .pins_count(pins_count), .guess_index(guess_index),
    .guess(guess), .secret(secret), .busy(busy), .done(done), .err(err), .green(green),
    .yellow(yellow), .ram_req(ram_req), .ram_gnt(ram_gnt), .ram_addr(ram_addr), .ram_wdata(ram_wdata)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // arbiter: random grant, or grant only after req has waited 3 cycles
  initial forever begin
    @(posedge clk); #2;
    if (lat_mode == 0) ram_gnt = 1'($urandom_range(0, 1));
    else if (!ram_req) begin ram_gnt = 0; hold = 0; end
    else if (hold >= 3) begin ram_gnt = 1; hold = 0; end
    else begin ram_gnt = 0; hold++; end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (ram_req) req_seen++;
    if (ram_req && ram_gnt) wq.push_back(int'({ram_addr, ram_wdata}));
    if (nrst && p_req && !p_gnt) check("ram_hold", {ram_req, ram_addr, ram_wdata}, {1'b1, p_addr, p_data});
    p_req = nrst && ram_req;
    p_gnt = ram_gnt;
    p_addr = ram_addr;
    p_data = ram_wdata;
  end

  task automatic set_pins(input logic [31:0] g, input logic [31:0] s);
    for (int k = 0; k < P; k++) begin
      tg[k] = k < 4 ? g[k*8 +: 8] : 8'd0;
      ts[k] = k < 4 ? s[k*8 +: 8] : 8'd0;
    end
  endtask

  task automatic load_inputs(input int pc, input int idx);
    for (int k = 0; k < P; k++) begin
      guess[k*8 +: 8] = tg[k];
      secret[k*8 +: 8] = ts[k];
    end
    pins_count = 8'(pc);
    guess_index = 8'(idx);
  endtask

  task automatic run(input int pc, input int idx, input int inj);
    int n, gr, ye;
    int cg[256], cs[256];
    int ex[$];
    bit got;
    n = pc > P ? P : pc;
    gr = 0;
    ye = 0;
    for (int k = 0; k < n; k++)
      if (tg[k] == ts[k]) gr++;
      else begin cg[tg[k]]++; cs[ts[k]]++; end
    for (int c = 0; c < 256; c++) ye += cg[c] < cs[c] ? cg[c] : cs[c];
`ifdef GUESS_HINT_RAM_UPLOAD_EN
    if (idx < G) begin
      for (int k = 0; k < n; k++) ex.push_back(((idx * P + k) << 8) | int'(tg[k]));
      ex.push_back(((HO + 2 * idx) << 8) | gr);
      ex.push_back(((HO + 2 * idx + 1) << 8) | ye);
    end
`endif
    load_inputs(pc, idx);
    @(posedge clk); #1;
    wq.delete();
    done_cnt = 0;
    req_seen = 0;
    start = 1;
    got = 0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(posedge clk); #1;
      start = 0;
      if (c == 0) check("busy", busy, 1);
      if (done) got = 1;
      else if (c == inj && busy) begin
        start = 1;
        guess = {5{32'($urandom)}};
        secret = {5{32'($urandom)}};
        pins_count = 8'($urandom);
      end
    end
    check("done_seen", got, 1);
    check("green", green, gr);
    check("yellow", yellow, ye);
    check("err", err, idx >= G);
    @(posedge clk); #1;
    check("done_pulse", done_cnt, 1);
    check("busy_idle", busy, 0);
    check("err_sticky", err, idx >= G);
    check("green_hold", green, gr);
`ifdef GUESS_HINT_RAM_UPLOAD_EN
    check("nwrites", wq.size(), ex.size());
    for (int i = 0; i < ex.size() && i < wq.size(); i++) check("write", wq[i], ex[i]);
`else
    check("ram_tied", req_seen + int'(ram_addr) + int'(ram_wdata), 0);
`endif
  endtask

  initial begin
    nrst = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", {busy, done, err, green, yellow, ram_req, ram_addr, ram_wdata}, 0);
    nrst = 1;
    set_pins(32'h04030201, 32'h04030201); run(4, 0, 2);
    set_pins(32'h01020304, 32'h04030201); run(4, 1, 2);
    set_pins(32'h02020101, 32'h04030201); run(4, 2, -1);
    lat_mode = 1;
    set_pins(32'h07050605, 32'h06060505); run(4, 3, 1);
    lat_mode = 0;
    set_pins(32'h04030201, 32'h04030201); run(4, 7, -1);
    run(4, 99, 2);
    run(0, 5, -1);
    for (int k = 0; k < P; k++) begin tg[k] = 8'($urandom_range(0, 3)); ts[k] = 8'($urandom_range(0, 3)); end
    run(25, 98, -1);
    // reset in the middle of a row upload
    set_pins(32'h04030201, 32'h01010101);
    lat_mode = 1;
    load_inputs(4, 7);
    @(posedge clk); #1;
    wq.delete();
    start = 1;
    @(posedge clk); #1;
    start = 0;
`ifdef GUESS_HINT_RAM_UPLOAD_EN
    for (int c = 0; c < 200 && !(ram_req && wq.size() >= 1); c++) begin @(posedge clk); #1; end
    check("mid_upload", ram_req && wq.size() >= 1, 1);
`else
    repeat (3) @(posedge clk);
    #1;
`endif
    nrst = 0;
    #1;
    check("rst_async", {busy, done, err, green, yellow, ram_req, ram_addr, ram_wdata}, 0);
    @(posedge clk); #1;
    check("rst_hold", {busy, done, err, green, yellow, ram_req, ram_addr, ram_wdata}, 0);
    nrst = 1;
    lat_mode = 0;
    run(4, 7, -1);
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < P; k++) begin tg[k] = 8'($urandom_range(0, 3)); ts[k] = 8'($urandom_range(0, 3)); end
      lat_mode = int'($urandom_range(0, 1));
      run(int'($urandom_range(0, 22)),
          $urandom_range(0, 3) == 0 ? int'($urandom_range(99, 255)) : int'($urandom_range(0, 98)),
          int'($urandom_range(0, 6)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
